// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-through, no-write-allocate data cache that sits between
// the MEM pipeline stage and Data_mem. Each line holds a valid bit, a tag and
// one 32-bit word. Load hits are served combinationally. A load miss or any
// store stalls the pipeline while a small FSM drives Data_mem.
//
// Byte order matches Data_mem: the byte at offset 0 is word bits [31:24].
//
// Parameters:
//   SETS          number of lines (power of two, >= 2)
//   MISS_LATENCY  cycles spent in REFILL (>= 1)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  MEM stage has an access this cycle
//   WE         access type: 000 lw, 010 lb, 110 lbu, 001 sw, 011 sb, other = no-op
//   A          byte address
//   WD         store data
//   RD         load result, sign- or zero-extended
//   stall      holds the pipeline; requester keeps its inputs stable meanwhile
//   mem_WE     to Data_mem WE
//   mem_A      to Data_mem A
//   mem_WD     to Data_mem WD
//   mem_RD     from Data_mem RD (asynchronous read)
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int SETS         = 8,
    parameter int MISS_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        stall,
    output logic [2:0]  mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam int IB = $clog2(SETS);
    localparam int TW = 30 - IB;
    localparam int CW = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    localparam logic [2:0] WE_LW  = 3'b000;
    localparam logic [2:0] WE_LB  = 3'b010;
    localparam logic [2:0] WE_LBU = 3'b110;
    localparam logic [2:0] WE_SW  = 3'b001;
    localparam logic [2:0] WE_SB  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS];

    // ---------------------------------------------------------------------
    // Request decode (live inputs)
    // ---------------------------------------------------------------------
    logic [IB-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic          is_load;
    logic          is_store;
    logic          hit;
    logic          load_hit;

    assign req_idx  = A[IB+1:2];
    assign req_tag  = A[31:IB+2];
    assign is_load  = req_valid && (WE == WE_LW || WE == WE_LB || WE == WE_LBU);
    assign is_store = req_valid && (WE == WE_SW || WE == WE_SB);
    assign hit      = req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign load_hit = (state == S_IDLE) && is_load && hit;

    // ---------------------------------------------------------------------
    // Line selected by the operation in flight. mem_A is captured on entry to
    // REFILL/WRITE, so the fill and the store update do not depend on the
    // requester still presenting the request (req_valid may drop in REFILL).
    // ---------------------------------------------------------------------
    logic [IB-1:0] op_idx;
    logic [TW-1:0] op_tag;
    logic          fill_en;
    logic          store_upd;

    assign op_idx    = mem_A[IB+1:2];
    assign op_tag    = mem_A[31:IB+2];
    assign fill_en   = (state == S_REFILL) && (cnt == '0);
    assign store_upd = (state == S_WRITE) && valid_q[op_idx] && (tag_q[op_idx] == op_tag);

    // ---------------------------------------------------------------------
    // Load result formatting
    // ---------------------------------------------------------------------
    logic [31:0] line_word;
    logic [7:0]  line_byte;

    assign line_word = data_q[req_idx];

    always_comb begin
        // NOTE: every path assigns a default first so no latch is inferred.
        line_byte = 8'h00;
        case (A[1:0])
            2'd0: line_byte = line_word[31:24];
            2'd1: line_byte = line_word[23:16];
            2'd2: line_byte = line_word[15:8];
            2'd3: line_byte = line_word[7:0];
            default: line_byte = 8'h00;
        endcase
    end

    always_comb begin
        RD = '0;
        if (load_hit) begin
            case (WE)
                WE_LW:   RD = line_word;
                WE_LB:   RD = {{24{line_byte[7]}}, line_byte};
                WE_LBU:  RD = {24'h0, line_byte};
                default: RD = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Stall: the IDLE decision is combinational so a miss or store holds the
    // pipeline in its detection cycle. Forced low while reset is asserted.
    // ---------------------------------------------------------------------
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state)
                S_IDLE:   stall = (is_load && !hit) || is_store;
                S_REFILL: stall = 1'b1;
                default:  stall = 1'b0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered memory-side outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            valid_q <= '0;
            mem_WE  <= WE_LW;
            mem_A   <= '0;
            mem_WD  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_load && !hit) begin
                        state <= S_REFILL;
                        cnt   <= CW'(MISS_LATENCY - 1);
                        mem_A <= {A[31:2], 2'b00};
                    end else if (is_store) begin
                        state  <= S_WRITE;
                        mem_WE <= WE;
                        mem_A  <= A;
                        mem_WD <= WD;
                    end
                end

                S_REFILL: begin
                    if (cnt == '0) begin
                        valid_q[op_idx] <= 1'b1;
                        state           <= S_IDLE;
                        mem_A           <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_WRITE: begin
                    state  <= S_IDLE;
                    mem_WE <= WE_LW;
                    mem_A  <= '0;
                    mem_WD <= '0;
                end

                default: begin
                    state  <= S_IDLE;
                    mem_WE <= WE_LW;
                    mem_A  <= '0;
                    mem_WD <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Tag and data storage. fill_en and store_upd are both zero while reset
    // holds the FSM in IDLE, so nothing is written during reset.
    // ---------------------------------------------------------------------
    // NOTE: tag/data arrays are not reset; the valid bits alone make stale
    // contents unreachable, which keeps the storage plain RAM.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[op_idx] <= mem_RD;
            tag_q[op_idx]  <= op_tag;
        end else if (store_upd) begin
            if (mem_WE == WE_SW) begin
                data_q[op_idx] <= mem_WD;
            end else begin
                case (mem_A[1:0])
                    2'd0: data_q[op_idx][31:24] <= mem_WD[7:0];
                    2'd1: data_q[op_idx][23:16] <= mem_WD[7:0];
                    2'd2: data_q[op_idx][15:8]  <= mem_WD[7:0];
                    2'd3: data_q[op_idx][7:0]   <= mem_WD[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
//
// Self-checking bench for data_cache (SETS=8, MISS_LATENCY=2). A byte-array
// Data_mem model answers the cache's memory port. A separate reference model
// tracks which address tags each set holds plus the expected memory image, and
// predicts stall cycles, load results and memory-side outputs per access.
// -----------------------------------------------------------------------------
module tb_data_cache;

    localparam int SETS = 8;
    localparam int LAT  = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        stall;
    logic [2:0]  mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    int checks = 0;
    int errors = 0;

    data_cache #(.SETS(SETS), .MISS_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .WE        (WE),
        .A         (A),
        .WD        (WD),
        .RD        (RD),
        .stall     (stall),
        .mem_WE    (mem_WE),
        .mem_A     (mem_A),
        .mem_WD    (mem_WD),
        .mem_RD    (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Data_mem model (256 bytes, big-endian) ----------------
    logic [7:0] dmem [256];

    always_comb begin
        mem_RD = {dmem[{mem_A[7:2], 2'd0}], dmem[{mem_A[7:2], 2'd1}],
                  dmem[{mem_A[7:2], 2'd2}], dmem[{mem_A[7:2], 2'd3}]};
    end

    always @(posedge clk) begin
        if (mem_WE == 3'b001) begin
            dmem[{mem_A[7:2], 2'd0}] <= mem_WD[31:24];
            dmem[{mem_A[7:2], 2'd1}] <= mem_WD[23:16];
            dmem[{mem_A[7:2], 2'd2}] <= mem_WD[15:8];
            dmem[{mem_A[7:2], 2'd3}] <= mem_WD[7:0];
        end else if (mem_WE == 3'b011) begin
            dmem[mem_A[7:0]] <= mem_WD[7:0];
        end
    end

    // ---------------- Reference model ----------------
    logic [7:0] ref_mem [256];
    bit         ref_valid [SETS];
    int         ref_tag   [SETS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a - (a % 4);
        return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] we, input int a);
        logic [31:0] w;
        logic [7:0]  b;
        w = ref_word(a);
        b = ref_mem[a];
        case (we)
            3'b000:  return w;
            3'b010:  return {{24{b[7]}}, b};
            3'b110:  return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
    endtask

    // Issue one access, count stall cycles, check results, update the model.
    task automatic run_op(input string name, input bit valid, input logic [2:0] we,
                          input int a, input logic [31:0] wd);
        int          set;
        int          tg;
        bit          ld;
        bit          st;
        bit          was_hit;
        int          exp_stall;
        logic [31:0] exp_rd;
        int          n;

        set     = (a / 4) % SETS;
        tg      = a / (4 * SETS);
        ld      = valid && (we == 3'b000 || we == 3'b010 || we == 3'b110);
        st      = valid && (we == 3'b001 || we == 3'b011);
        was_hit = ref_valid[set] && ref_tag[set] == tg;
        exp_stall = ld ? (was_hit ? 0 : LAT + 1) : (st ? 1 : 0);
        exp_rd    = ld ? ref_load(we, a) : 32'h0;

        req_valid = valid;
        WE        = we;
        A         = 32'(a);
        WD        = wd;

        n = 0;
        @(negedge clk);
        while (stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({name, ".stall_cycles"}, 32'(n), 32'(exp_stall));
        if (st) begin
            check({name, ".mem_WE"}, {29'h0, mem_WE}, {29'h0, we});
            check({name, ".mem_A"},  mem_A, 32'(a));
            check({name, ".mem_WD"}, mem_WD, wd);
        end else begin
            check({name, ".RD"}, RD, exp_rd);
            check({name, ".idle_mem_WE"}, {29'h0, mem_WE}, 32'h0);
        end

        @(posedge clk);
        #1;
        req_valid = 1'b0;

        if (ld && !was_hit) begin
            ref_valid[set] = 1'b1;
            ref_tag[set]   = tg;
        end
        if (st && we == 3'b001) begin
            for (int k = 0; k < 4; k++) ref_mem[a - (a % 4) + k] = wd[31 - 8*k -: 8];
        end else if (st) begin
            ref_mem[a] = wd[7:0];
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        ref_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] codes [8];
        int         a;
        logic [2:0] we;

        codes = '{3'b000, 3'b010, 3'b110, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111};

        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        dmem[16'h10] = 8'h11; dmem[16'h11] = 8'h22; dmem[16'h12] = 8'h33; dmem[16'h13] = 8'h84;
        for (int i = 16; i < 20; i++) ref_mem[i] = dmem[i];
        ref_clear();

        // Reset state, with a load request presented during reset.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        WE        = 3'b000;
        A         = 32'h10;
        WD        = 32'h0;
        #2;
        check("reset.stall",  {31'h0, stall}, 32'h0);
        check("reset.RD",     RD, 32'h0);
        check("reset.mem_WE", {29'h0, mem_WE}, 32'h0);
        check("reset.mem_A",  mem_A, 32'h0);
        check("reset.mem_WD", mem_WD, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold load and refill, then an immediate repeat hit.
        run_op("cold_lw",   1, 3'b000, 'h10, 0);
        run_op("repeat_lw", 1, 3'b000, 'h10, 0);
        check("cold_lw.value", ref_word('h10), 32'h11223384);

        // Byte loads on the filled line.
        run_op("lb_13",  1, 3'b010, 'h13, 0);
        run_op("lbu_13", 1, 3'b110, 'h13, 0);
        run_op("lb_11",  1, 3'b010, 'h11, 0);

        // Store-byte hit, then word read shows the new byte.
        run_op("sb_11",    1, 3'b011, 'h11, 32'h000000AA);
        run_op("lw_after_sb", 1, 3'b000, 'h10, 0);
        check("sb.dmem", {24'h0, dmem[8'h11]}, 32'h000000AA);

        // Conflict eviction on index 4.
        run_op("evict_lw30", 1, 3'b000, 'h30, 0);
        run_op("evict_lw10", 1, 3'b000, 'h10, 0);

        // No-write-allocate on an empty line.
        apply_reset();
        run_op("nwa_sw50", 1, 3'b001, 'h50, 32'hDEADBEEF);
        run_op("nwa_lw50", 1, 3'b000, 'h50, 0);

        // Reset during the second REFILL cycle.
        apply_reset();
        req_valid = 1'b1;
        WE        = 3'b000;
        A         = 32'h10;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midrst.refill_stall", {31'h0, stall}, 32'h1);
        check("midrst.refill_mem_A", mem_A, 32'h10);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        ref_clear();
        #1;
        check("midrst.stall", {31'h0, stall}, 32'h0);
        check("midrst.mem_A", mem_A, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("midrst_reissue", 1, 3'b000, 'h10, 0);

        // Randomized traffic over a small, heavily conflicting address range.
        for (int i = 0; i < 300; i++) begin
            a  = int'($urandom_range(0, 127));
            we = codes[$urandom_range(0, 7)];
            run_op("rand", ($urandom_range(0, 7) != 0), we, a, $urandom);
        end

        // Memory image must match the model after all traffic.
        for (int i = 0; i < 128; i += 4) begin
            check("final_mem", {dmem[i], dmem[i+1], dmem[i+2], dmem[i+3]}, ref_word(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
